// File: rtl/sfilter_control_pkg.sv
// Shared LPC constants and the synthesis sequencer state encoding.
package sfilter_control_pkg;

  localparam int LPC_ORDER = 10;
  localparam int LPC_FRAME = 160;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sfilter_control.sv
// LPC synthesis filter sequencer: per sample LOAD, min(n,ORDER) taps, MAC_LAT drain, WRITE.
// All outputs decode registered state; start only matters in IDLE/DONE.
module sfilter_control
  import sfilter_control_pkg::*;
#(
  parameter int ORDER   = LPC_ORDER,
  parameter int FRAME   = LPC_FRAME,
  parameter int MAC_LAT = 1,
  parameter int AW      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  output logic             next_sample,
  output logic [AW-1:0]    residue_raddr,
  output logic [ORDER-1:0] a_rsel,
  output logic [AW-1:0]    y_raddr,
  output logic [AW-1:0]    y_waddr,
  output logic             y_wen
);

  localparam int KW = $clog2(ORDER + 1);
  // With no datapath latency the result is usable right after the last tap.
  localparam state_t POST_TAPS = (MAC_LAT == 0) ? ST_WRITE : ST_DRAIN;

  state_t        state, state_nxt;
  logic [AW-1:0] n, n_nxt;
  logic [KW-1:0] k, k_nxt;
  logic [2:0]    d, d_nxt;
  logic [KW-1:0] k_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      n     <= '0;
      k     <= '0;
      d     <= '0;
    end else begin
      state <= state_nxt;
      n     <= n_nxt;
      k     <= k_nxt;
      d     <= d_nxt;
    end
  end

  always_comb begin
    k_last = (n >= AW'(ORDER)) ? KW'(ORDER) : KW'(n);
  end

  always_comb begin
    state_nxt = state;
    n_nxt     = n;
    k_nxt     = k;
    d_nxt     = d;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_LOAD;
          n_nxt     = '0;
        end
      end
      ST_LOAD: begin
        d_nxt = '0;
        if (n == '0) begin
          state_nxt = POST_TAPS;
        end else begin
          state_nxt = ST_MAC;
          k_nxt     = KW'(1);
        end
      end
      ST_MAC: begin
        if (k == k_last) begin
          state_nxt = POST_TAPS;
          d_nxt     = '0;
        end else begin
          k_nxt = k + KW'(1);
        end
      end
      ST_DRAIN: begin
        if (d == 3'(MAC_LAT - 1)) state_nxt = ST_WRITE;
        else                      d_nxt     = d + 3'd1;
      end
      ST_WRITE: begin
        if (n == AW'(FRAME - 1)) begin
          state_nxt = ST_DONE;
        end else begin
          n_nxt     = n + AW'(1);
          state_nxt = ST_LOAD;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // k >= 1 whenever MAC is active, so n-k stays non-negative.
  always_comb begin
    ready         = (state == ST_DONE);
    next_sample   = (state == ST_LOAD);
    residue_raddr = (state == ST_LOAD) ? n : '0;
    a_rsel        = (state == ST_MAC) ? (ORDER'(1) << (k - KW'(1))) : '0;
    y_raddr       = (state == ST_MAC) ? (n - AW'(k)) : '0;
    y_wen         = (state == ST_WRITE);
    y_waddr       = (state == ST_WRITE) ? n : '0;
  end

endmodule

// File: tb/tb_sfilter_control.sv
// Bench: directed checks on the MAC_LAT=1 build plus per-sample cycle scoreboards on MAC_LAT=0/1/3 builds.
module tb_sfilter_control;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;

  logic       rdy [3];
  logic       ns  [3];
  logic       wen [3];
  logic [7:0] rr  [3];
  logic [7:0] yr  [3];
  logic [7:0] yw  [3];
  logic [9:0] ars [3];

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int c0   = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

    sfilter_control #(.MAC_LAT(L)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .ready        (rdy[g]),
      .next_sample  (ns[g]),
      .residue_raddr(rr[g]),
      .a_rsel       (ars[g]),
      .y_raddr      (yr[g]),
      .y_waddr      (yw[g]),
      .y_wen        (wen[g])
    );

    // Reference model: LOAD..WRITE span must equal 2 + L + min(n,10).
    initial begin
      int sc;
      int sn;
      sc = 0;
      sn = 0;
      forever begin
        @(negedge clk);
        if (!reset) begin
          sc = 0;
        end else if (ns[g]) begin
          sc = 1;
          sn = int'(rr[g]);
        end else if (sc > 0) begin
          sc++;
          if (wen[g]) begin
            check($sformatf("sb%0d_cycles_n%0d", L, sn), sc, 2 + L + ((sn < 10) ? sn : 10));
            check($sformatf("sb%0d_waddr", L), int'(yw[g]), sn);
            sc = 0;
          end
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic all_zero(input string tag);
    for (int g = 0; g < 3; g++) begin
      check({tag, "_ready"}, int'(rdy[g]), 0);
      check({tag, "_wen"},   int'(wen[g]), 0);
      check({tag, "_arsel"}, int'(ars[g]), 0);
      check({tag, "_next"},  int'(ns[g]),  0);
    end
    check({tag, "_rraddr"}, int'(rr[1]), 0);
    check({tag, "_yraddr"}, int'(yr[1]), 0);
    check({tag, "_ywaddr"}, int'(yw[1]), 0);
  endtask

  task automatic wait_load(input int target);
    int b;
    b = 0;
    while (!(ns[1] && int'(rr[1]) == target) && b < 3000) begin
      step();
      b++;
    end
    check($sformatf("reach_load_n%0d", target), int'(ns[1] && int'(rr[1]) == target), 1);
  endtask

  initial begin
    int b;
    repeat (3) @(negedge clk);
    all_zero("reset");

    reset = 1'b1;
    step();
    check("idle_ready", int'(rdy[1]), 0);
    check("idle_next", int'(ns[1]), 0);

    // Frame start: n=0 has no taps.
    start = 1'b1;
    step();
    start = 1'b0;
    check("n0_load", int'(ns[1]), 1);
    check("n0_rraddr", int'(rr[1]), 0);
    check("n0_arsel", int'(ars[1]), 0);
    step();
    check("n0_drain_wen", int'(wen[1]), 0);
    check("n0_drain_arsel", int'(ars[1]), 0);
    step();
    check("n0_wen", int'(wen[1]), 1);
    check("n0_waddr", int'(yw[1]), 0);

    // Ramp-up at n=3.
    wait_load(3);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("n3_arsel_t%0d", i), int'(ars[1]), 1 << i);
      check($sformatf("n3_yraddr_t%0d", i), int'(yr[1]), 2 - i);
    end
    step();
    check("n3_drain_wen", int'(wen[1]), 0);
    check("n3_drain_arsel", int'(ars[1]), 0);
    step();
    check("n3_wen", int'(wen[1]), 1);
    check("n3_waddr", int'(yw[1]), 3);

    // Reset mid-MAC at n=37, k=4.
    wait_load(37);
    repeat (4) step();
    check("n37_k4_arsel", int'(ars[1]), 8);
    check("n37_k4_yraddr", int'(yr[1]), 33);
    #2 reset = 1'b0;
    #1 all_zero("rst_async");
    @(negedge clk);
    all_zero("rst_hold");
    reset = 1'b1;
    step();
    check("post_rst_idle_next", int'(ns[1]), 0);
    check("post_rst_idle_ready", int'(rdy[1]), 0);

    // Fresh frame.
    start = 1'b1;
    step();
    start = 1'b0;
    c0 = cyc;
    check("f2_load", int'(ns[1]), 1);
    check("f2_rraddr", int'(rr[1]), 0);

    // start mid-frame is ignored.
    wait_load(80);
    start = 1'b1;
    step();
    start = 1'b0;
    check("n80_next", int'(ns[1]), 0);
    check("n80_arsel", int'(ars[1]), 1);
    check("n80_yraddr", int'(yr[1]), 79);
    step();
    check("n80_arsel_t2", int'(ars[1]), 2);
    check("n80_yraddr_t2", int'(yr[1]), 78);

    // Full order at the last sample.
    wait_load(159);
    for (int kk = 1; kk <= 10; kk++) begin
      step();
      check($sformatf("n159_arsel_k%0d", kk), int'(ars[1]), 1 << (kk - 1));
      check($sformatf("n159_yraddr_k%0d", kk), int'(yr[1]), 159 - kk);
    end
    step();
    check("n159_drain_wen", int'(wen[1]), 0);
    step();
    check("n159_wen", int'(wen[1]), 1);
    check("n159_waddr", int'(yw[1]), 159);
    check("n159_ready_early", int'(rdy[1]), 0);
    step();
    check("done_ready", int'(rdy[1]), 1);
    check("done_wen", int'(wen[1]), 0);
    check("frame_cycles", cyc - c0, 2025);
    step();
    check("done_ready_held", int'(rdy[1]), 1);

    // start held high in DONE restarts immediately.
    start = 1'b1;
    step();
    check("restart_ready", int'(rdy[1]), 0);
    check("restart_load", int'(ns[1]), 1);
    check("restart_rraddr", int'(rr[1]), 0);
    step();
    check("restart_drain_next", int'(ns[1]), 0);
    check("restart_drain_ready", int'(rdy[1]), 0);
    start = 1'b0;

    // Let the slower builds finish so their scoreboards cover a whole frame.
    b = 0;
    while (!rdy[2] && b < 3000) begin
      step();
      b++;
    end
    check("lat3_frame_done", int'(rdy[2]), 1);
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
